vga_stream_monitor: RTL and testbench
=====================================

Name: vga_stream_monitor

Overview:
- Receive-side checker for the VGA pixel stream that vga_controller drives: HS, VS, BLANK_n and 8-bit B/G/R.
- Recovers frame geometry from the sync and blank signals, checks it against the expected 640x480 active area, and computes a per-frame pixel checksum.
- Captures the colour at one probe coordinate per frame.
- Sits beside the display path (on-board self-test and bench scoreboard); it does not drive the display.

Parameters:
- EXP_H_ACTIVE, 640, expected active pixels per line
- EXP_V_ACTIVE, 480, expected active lines per frame
- LOCK_FRAMES, 2, consecutive good frames required to assert oLocked

Ports:
- iVGA_CLK  in  1  pixel clock; all logic on its rising edge
- iRST_n  in  1  reset, asynchronous, active-low
- iHS  in  1  horizontal sync, active-low pulse
- iVS  in  1  vertical sync, active-low pulse
- iBLANK_n  in  1  1 = active pixel
- iB_data, iG_data, iR_data  in  8 each  pixel colour
- iProbeX  in  10  probe column, active-area coordinates
- iProbeY  in  9  probe row, active-area coordinates
- oFrameDone  out  1  one-cycle pulse when a frame's results are latched
- oActiveWidth  out  11  active pixels in the first active line of the last frame
- oActiveLines  out  10  active lines in the last frame
- oLineTotal  out  10  HS falling edges counted in the last frame
- oChecksum  out  32  sum modulo 2^32 of {B,G,R} over the last frame's active pixels
- oProbeColor  out  24  {B,G,R} at the probe point in the last frame; 0 if the point was never reached
- oFrameOk  out  1  last frame matched the expected geometry
- oLocked  out  1  LOCK_FRAMES or more consecutive good frames
- oErrCount  out  8  bad frames, saturating at 255

Behaviour:
- Input stage: all inputs registered once, so one cycle of latency. Edges are detected on the registered copies:
  - HS fall: previous 1, current 0.
  - VS fall: previous 1, current 0.
  - Active end: BLANK_n previous 1, current 0.
- State machine:
  - SEEK (the reset state): waits for VS fall, then moves to FRAME and clears the per-frame accumulators.
  - FRAME: on each VS fall the block closes the frame (below), re-opens new accumulators in the same cycle, and stays in FRAME.
- Per-frame accumulators, all cleared when a frame opens:
  - x: 11-bit; +1 each active cycle, saturates at 2047; cleared on HS fall.
  - y: 10-bit active-line count; +1 on each active end, saturates at 1023.
  - line count: 10-bit; +1 on HS fall, saturates.
  - sum: 32-bit; += {B,G,R} each active cycle, wraps.
  - first_w: x latched at the first active end of the frame.
  - line_err: set when any later active end has x != first_w.
  - probe: iProbeX/iProbeY sampled at frame open; when an active cycle has x == probeX and y == probeY, the pixel is stored. Coordinates use the pre-increment x and the current y.
- Frame close, on VS fall while in FRAME:
  - Outputs latched: oActiveWidth=first_w, oActiveLines=y, oLineTotal=line count, oChecksum=sum (including any pixel in the closing cycle), oProbeColor.
  - oFrameDone pulses for exactly 1 cycle.
  - Good frame: first_w==EXP_H_ACTIVE, y==EXP_V_ACTIVE and !line_err.
  - Good frame result: oFrameOk=1, consecutive-good counter +1 (saturating at 255); oLocked=1 once the counter reaches LOCK_FRAMES.
  - Bad frame result: oFrameOk=0, counter cleared, oLocked=0, oErrCount +1 (saturating).
  - Frame with y==0 (no active video) counts as a bad frame.
- The first VS fall after reset only opens a frame: no oFrameDone and no error.
- Simultaneous events:
  - HS fall and active end in the same cycle: y increments and x clears.
  - VS fall and an active pixel in the same cycle: the pixel belongs to the closing frame.
- Reset, asynchronous and valid at any time including mid-frame:
  - All outputs and accumulators go to 0 and the state returns to SEEK.
  - The partial frame is discarded; oErrCount is not incremented.

Test Plan:
- Standard 800x525 timing (640x480 active), constant colour 0x0000FF, 3 frames -> first VS fall gives no pulse. Each later close gives: oActiveWidth=640, oActiveLines=480, oLineTotal=525, oChecksum=78,336,000, oFrameOk=1. oLocked=1 after the 2nd close.
- Locked stream, then one frame where line 100 has 639 active pixels -> that close gives oFrameOk=0, oLocked=0, oErrCount=1. After two further good frames, oLocked=1.
- Probe (10,20); pixel colour = {B=0, G=y, R=x} -> oProbeColor=0x00140A. Probe (700,20) -> oProbeColor=0.
- Frame with 479 active lines -> oActiveLines=479, oFrameOk=0, oErrCount increments.
- iRST_n pulsed low mid-frame -> all outputs 0 immediately. The next VS fall gives no oFrameDone; the following close reports a full valid frame.
- Stream with BLANK_n held 0 for a whole frame -> that close gives oActiveLines=0, oFrameOk=0, oChecksum=0.

Source files
------------

// File: rtl/vga_stream_monitor_if.sv
// Bundles the observed VGA stream, the probe coordinates and the per-frame results
// so that the monitor and its stimulus source share one set of signal definitions.
interface vga_stream_monitor_if;
    logic        iHS;
    logic        iVS;
    logic        iBLANK_n;
    logic [7:0]  iB_data;
    logic [7:0]  iG_data;
    logic [7:0]  iR_data;
    logic [9:0]  iProbeX;
    logic [8:0]  iProbeY;

    logic        oFrameDone;
    logic [10:0] oActiveWidth;
    logic [9:0]  oActiveLines;
    logic [9:0]  oLineTotal;
    logic [31:0] oChecksum;
    logic [23:0] oProbeColor;
    logic        oFrameOk;
    logic        oLocked;
    logic [7:0]  oErrCount;

    modport master (
        output iHS, iVS, iBLANK_n, iB_data, iG_data, iR_data, iProbeX, iProbeY,
        input  oFrameDone, oActiveWidth, oActiveLines, oLineTotal, oChecksum,
               oProbeColor, oFrameOk, oLocked, oErrCount
    );

    modport slave (
        input  iHS, iVS, iBLANK_n, iB_data, iG_data, iR_data, iProbeX, iProbeY,
        output oFrameDone, oActiveWidth, oActiveLines, oLineTotal, oChecksum,
               oProbeColor, oFrameOk, oLocked, oErrCount
    );
endinterface

// File: rtl/vga_stream_monitor.sv
// Passive VGA stream checker: recovers active geometry between VS falls, checksums the
// active pixels, samples one probe pixel and tracks lock / error statistics per frame.
module vga_stream_monitor #(
    parameter int unsigned EXP_H_ACTIVE = 640,
    parameter int unsigned EXP_V_ACTIVE = 480,
    parameter int unsigned LOCK_FRAMES  = 2
) (
    input logic                 iVGA_CLK,
    input logic                 iRST_n,
    vga_stream_monitor_if.slave bus
);

    typedef enum logic [0:0] {StSeek, StFrame} state_e;

    state_e state_q, state_d;

    // Input stage plus one-deep history for edge detection
    logic        hs_q, hs_prev_q, vs_q, vs_prev_q, blank_q, blank_prev_q;
    logic [23:0] pix_q;
    logic [9:0]  probe_x_in_q;
    logic [8:0]  probe_y_in_q;

    // Per-frame accumulators
    logic [10:0] x_q, x_d, first_w_q, first_w_d;
    logic [9:0]  y_q, y_d, lines_q, lines_d;
    logic [31:0] sum_q, sum_d;
    logic        first_seen_q, first_seen_d, line_err_q, line_err_d;
    logic [9:0]  probe_x_q, probe_x_d;
    logic [8:0]  probe_y_q, probe_y_d;
    logic [23:0] probe_pix_q, probe_pix_d;

    // Values including the current cycle, before any frame re-open
    logic [10:0] x_acc, first_w_acc;
    logic [9:0]  y_acc, lines_acc;
    logic [31:0] sum_acc;
    logic        first_seen_acc, line_err_acc;
    logic [23:0] probe_pix_acc;

    logic [7:0]  good_cnt_q, good_cnt_d, err_cnt_q, err_cnt_d;
    logic        frame_done_q, frame_ok_q, frame_ok_d, locked_q, locked_d;
    logic [10:0] out_width_q;
    logic [9:0]  out_lines_q, out_total_q;
    logic [31:0] out_sum_q;
    logic [23:0] out_probe_q;

    logic hs_fall, vs_fall, active_end, probe_hit, open_frame, close_frame, good_frame;

    assign hs_fall    = hs_prev_q & ~hs_q;
    assign vs_fall    = vs_prev_q & ~vs_q;
    assign active_end = blank_prev_q & ~blank_q;

    always_comb begin
        state_d     = state_q;
        open_frame  = 1'b0;
        close_frame = 1'b0;
        unique case (state_q)
            StSeek: begin
                if (vs_fall) begin
                    state_d    = StFrame;
                    open_frame = 1'b1;
                end
            end
            StFrame: begin
                if (vs_fall) begin
                    open_frame  = 1'b1;
                    close_frame = 1'b1;
                end
            end
            default: state_d = StSeek;
        endcase
    end

    always_comb begin
        x_acc = x_q;
        if (hs_fall) begin
            x_acc = '0;
        end else if (blank_q && x_q != '1) begin
            x_acc = x_q + 11'd1;
        end
        y_acc     = (active_end && y_q != '1) ? y_q + 10'd1 : y_q;
        lines_acc = (hs_fall && lines_q != '1) ? lines_q + 10'd1 : lines_q;
        sum_acc   = blank_q ? sum_q + {8'd0, pix_q} : sum_q;

        first_w_acc    = first_w_q;
        first_seen_acc = first_seen_q;
        line_err_acc   = line_err_q;
        if (active_end) begin
            if (!first_seen_q) begin
                first_w_acc    = x_q;
                first_seen_acc = 1'b1;
            end else if (x_q != first_w_q) begin
                line_err_acc = 1'b1;
            end
        end

        probe_hit     = blank_q && (x_q == {1'b0, probe_x_q}) && (y_q == {1'b0, probe_y_q});
        probe_pix_acc = probe_hit ? pix_q : probe_pix_q;

        good_frame = (first_w_acc == 11'(EXP_H_ACTIVE)) && (y_acc == 10'(EXP_V_ACTIVE)) &&
                     (y_acc != '0) && !line_err_acc;
    end

    always_comb begin
        x_d          = x_acc;
        y_d          = y_acc;
        lines_d      = lines_acc;
        sum_d        = sum_acc;
        first_w_d    = first_w_acc;
        first_seen_d = first_seen_acc;
        line_err_d   = line_err_acc;
        probe_pix_d  = probe_pix_acc;
        probe_x_d    = probe_x_q;
        probe_y_d    = probe_y_q;
        if (open_frame) begin
            x_d          = '0;
            y_d          = '0;
            lines_d      = '0;
            sum_d        = '0;
            first_w_d    = '0;
            first_seen_d = 1'b0;
            line_err_d   = 1'b0;
            probe_pix_d  = '0;
            probe_x_d    = probe_x_in_q;
            probe_y_d    = probe_y_in_q;
        end

        good_cnt_d = good_cnt_q;
        err_cnt_d  = err_cnt_q;
        frame_ok_d = frame_ok_q;
        locked_d   = locked_q;
        if (close_frame) begin
            frame_ok_d = good_frame;
            if (good_frame) begin
                good_cnt_d = (good_cnt_q != '1) ? good_cnt_q + 8'd1 : good_cnt_q;
                locked_d   = (good_cnt_d >= 8'(LOCK_FRAMES));
            end else begin
                good_cnt_d = '0;
                locked_d   = 1'b0;
                err_cnt_d  = (err_cnt_q != '1) ? err_cnt_q + 8'd1 : err_cnt_q;
            end
        end
    end

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q      <= StSeek;
            hs_q         <= 1'b0;
            hs_prev_q    <= 1'b0;
            vs_q         <= 1'b0;
            vs_prev_q    <= 1'b0;
            blank_q      <= 1'b0;
            blank_prev_q <= 1'b0;
            pix_q        <= '0;
            probe_x_in_q <= '0;
            probe_y_in_q <= '0;
            x_q          <= '0;
            y_q          <= '0;
            lines_q      <= '0;
            sum_q        <= '0;
            first_w_q    <= '0;
            first_seen_q <= 1'b0;
            line_err_q   <= 1'b0;
            probe_x_q    <= '0;
            probe_y_q    <= '0;
            probe_pix_q  <= '0;
            good_cnt_q   <= '0;
            err_cnt_q    <= '0;
            frame_done_q <= 1'b0;
            frame_ok_q   <= 1'b0;
            locked_q     <= 1'b0;
            out_width_q  <= '0;
            out_lines_q  <= '0;
            out_total_q  <= '0;
            out_sum_q    <= '0;
            out_probe_q  <= '0;
        end else begin
            state_q      <= state_d;
            hs_q         <= bus.iHS;
            hs_prev_q    <= hs_q;
            vs_q         <= bus.iVS;
            vs_prev_q    <= vs_q;
            blank_q      <= bus.iBLANK_n;
            blank_prev_q <= blank_q;
            pix_q        <= {bus.iB_data, bus.iG_data, bus.iR_data};
            probe_x_in_q <= bus.iProbeX;
            probe_y_in_q <= bus.iProbeY;
            x_q          <= x_d;
            y_q          <= y_d;
            lines_q      <= lines_d;
            sum_q        <= sum_d;
            first_w_q    <= first_w_d;
            first_seen_q <= first_seen_d;
            line_err_q   <= line_err_d;
            probe_x_q    <= probe_x_d;
            probe_y_q    <= probe_y_d;
            probe_pix_q  <= probe_pix_d;
            good_cnt_q   <= good_cnt_d;
            err_cnt_q    <= err_cnt_d;
            frame_done_q <= close_frame;
            frame_ok_q   <= frame_ok_d;
            locked_q     <= locked_d;
            if (close_frame) begin
                out_width_q <= first_w_acc;
                out_lines_q <= y_acc;
                out_total_q <= lines_acc;
                out_sum_q   <= sum_acc;
                out_probe_q <= probe_pix_acc;
            end
        end
    end

    assign bus.oFrameDone   = frame_done_q;
    assign bus.oActiveWidth = out_width_q;
    assign bus.oActiveLines = out_lines_q;
    assign bus.oLineTotal   = out_total_q;
    assign bus.oChecksum    = out_sum_q;
    assign bus.oProbeColor  = out_probe_q;
    assign bus.oFrameOk     = frame_ok_q;
    assign bus.oLocked      = locked_q;
    assign bus.oErrCount    = err_cnt_q;

endmodule

// File: tb/tb_vga_stream_monitor.sv
// Directed frame-level bench for vga_stream_monitor using a scaled-down 24x16 raster
// with a 16x12 active area; expected results per frame are hand-computed in the table.
module tb_vga_stream_monitor;

    localparam int HA = 16;
    localparam int VA = 12;
    localparam int HT = 24;
    localparam int VT = 16;

    typedef struct {
        int          va;
        int          short_line;
        int          short_len;
        bit          blank_all;
        bit          grad;
        int          px;
        int          py;
        int          hs_pos;
        bit          stray;
        int          rst_line;
        int          e_done;
        int          e_width;
        int          e_lines;
        int          e_total;
        logic [31:0] e_sum;
        int          e_probe;
        int          e_ok;
        int          e_lk;
        int          e_err;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;

    vga_stream_monitor_if mon ();

    vga_stream_monitor #(
        .EXP_H_ACTIVE(HA),
        .EXP_V_ACTIVE(VA),
        .LOCK_FRAMES (2)
    ) dut (
        .iVGA_CLK(clk),
        .iRST_n  (rst_n),
        .bus     (mon)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mon.oFrameDone) done_cnt <= done_cnt + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int va, sl, slen, input bit ba, gr, input int px, py, hsp,
                                input bit st, input int rl, input int ed, ew, el, et,
                                input logic [31:0] es, input int ep, eo, ek, ee);
        vec_t v;
        v.va = va; v.short_line = sl; v.short_len = slen; v.blank_all = ba; v.grad = gr;
        v.px = px; v.py = py; v.hs_pos = hsp; v.stray = st; v.rst_line = rl;
        v.e_done = ed; v.e_width = ew; v.e_lines = el; v.e_total = et; v.e_sum = es;
        v.e_probe = ep; v.e_ok = eo; v.e_lk = ek; v.e_err = ee;
        return v;
    endfunction

    // Drives one raster frame; probe for the following frame is set before this frame's VS.
    task automatic gen_frame(input vec_t v, input int nxt_px, input int nxt_py);
        for (int ln = 0; ln < VT; ln++) begin
            for (int c = 0; c < HT; c++) begin
                int  w;
                bit  act;
                @(negedge clk);
                if (ln == v.rst_line && c == 3) begin
                    rst_n = 1'b0;
                    #1;
                    chk("rst_sum", mon.oChecksum, 32'd0);
                    chk("rst_flags", 32'({mon.oFrameDone, mon.oFrameOk, mon.oLocked}), 32'd0);
                    chk("rst_err", 32'(mon.oErrCount), 32'd0);
                    chk("rst_geom", 32'({mon.oActiveWidth, mon.oActiveLines, mon.oLineTotal}), 32'd0);
                end
                if (ln == v.rst_line && c == 6) rst_n = 1'b1;
                w   = (ln == v.short_line) ? v.short_len : HA;
                act = !v.blank_all && ln < v.va && c < w;
                mon.iBLANK_n = act;
                mon.iB_data  = 8'h00;
                mon.iG_data  = v.grad ? 8'(ln) : 8'h00;
                mon.iR_data  = v.grad ? 8'(c) : 8'hFF;
                if (v.stray && ln == VT - 3 && c == 0) begin
                    mon.iBLANK_n = 1'b1;
                    {mon.iB_data, mon.iG_data, mon.iR_data} = 24'h123456;
                end
                mon.iHS = (c >= v.hs_pos && c < v.hs_pos + 3) ? 1'b0 : 1'b1;
                mon.iVS = (ln == VT - 3 || ln == VT - 2) ? 1'b0 : 1'b1;
                if (ln == VT - 4 && c == 0) begin
                    mon.iProbeX = 10'(nxt_px);
                    mon.iProbeY = 9'(nxt_py);
                end
            end
        end
    endtask

    vec_t tv[$];

    initial begin
        int d0;
        // va sl slen ba gr px py hs st rst | done w lines tot sum probe ok lk err
        tv.push_back(mk(12, -1, 16, 0, 0, 0, 0, 18, 0, -1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tv.push_back(mk(12, -1, 16, 0, 0, 0, 0, 18, 0, -1, 1, 16, 12, 16, 48960, 'hFF, 1, 0, 0));
        tv.push_back(mk(12, -1, 16, 0, 0, 0, 0, 18, 0, -1, 1, 16, 12, 16, 48960, 'hFF, 1, 1, 0));
        tv.push_back(mk(12, 5, 15, 0, 0, 0, 0, 18, 0, -1, 1, 16, 12, 16, 48705, 'hFF, 0, 0, 1));
        tv.push_back(mk(12, -1, 16, 0, 0, 0, 0, 18, 0, -1, 1, 16, 12, 16, 48960, 'hFF, 1, 0, 1));
        tv.push_back(mk(12, -1, 16, 0, 0, 0, 0, 18, 0, -1, 1, 16, 12, 16, 48960, 'hFF, 1, 1, 1));
        tv.push_back(mk(12, -1, 16, 0, 1, 10, 7, 18, 0, -1, 1, 16, 12, 16, 271776, 'h00070A, 1, 1, 1));
        tv.push_back(mk(12, -1, 16, 0, 1, 20, 7, 18, 0, -1, 1, 16, 12, 16, 271776, 0, 1, 1, 1));
        tv.push_back(mk(11, -1, 16, 0, 0, 0, 0, 18, 0, -1, 1, 16, 11, 16, 44880, 'hFF, 0, 0, 2));
        tv.push_back(mk(12, -1, 16, 1, 0, 0, 0, 18, 0, -1, 1, 0, 0, 16, 0, 0, 0, 0, 3));
        tv.push_back(mk(12, 0, 17, 0, 0, 0, 0, 18, 0, -1, 1, 17, 12, 16, 49215, 'hFF, 0, 0, 4));
        tv.push_back(mk(12, -1, 16, 0, 0, 0, 0, 16, 0, -1, 1, 16, 12, 16, 48960, 'hFF, 1, 0, 4));
        tv.push_back(mk(12, -1, 16, 0, 0, 0, 0, 18, 0, -1, 1, 16, 12, 16, 48960, 'hFF, 1, 1, 4));
        tv.push_back(mk(12, -1, 16, 0, 0, 0, 0, 18, 1, -1, 1, 16, 12, 16, 1242006, 'hFF, 1, 1, 4));
        tv.push_back(mk(12, -1, 16, 0, 0, 0, 0, 18, 0, -1, 1, 0, 13, 16, 48960, 0, 0, 0, 5));
        tv.push_back(mk(12, -1, 16, 0, 0, 0, 0, 18, 0, -1, 1, 16, 12, 16, 48960, 'hFF, 1, 0, 5));
        tv.push_back(mk(12, -1, 16, 0, 0, 0, 0, 18, 0, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tv.push_back(mk(12, -1, 16, 0, 0, 0, 0, 18, 0, -1, 1, 16, 12, 16, 48960, 'hFF, 1, 0, 0));
        tv.push_back(mk(12, -1, 16, 0, 0, 0, 0, 18, 0, -1, 1, 16, 12, 16, 48960, 'hFF, 1, 1, 0));

        mon.iHS = 1'b1; mon.iVS = 1'b1; mon.iBLANK_n = 1'b0;
        mon.iB_data = 8'h00; mon.iG_data = 8'h00; mon.iR_data = 8'h00;
        mon.iProbeX = 10'd0; mon.iProbeY = 9'd0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < tv.size(); i++) begin
            int npx, npy;
            npx = (i + 1 < tv.size()) ? tv[i + 1].px : 0;
            npy = (i + 1 < tv.size()) ? tv[i + 1].py : 0;
            d0 = done_cnt;
            gen_frame(tv[i], npx, npy);
            chk($sformatf("f%0d_done", i), 32'(done_cnt - d0), 32'(tv[i].e_done));
            chk($sformatf("f%0d_width", i), 32'(mon.oActiveWidth), 32'(tv[i].e_width));
            chk($sformatf("f%0d_lines", i), 32'(mon.oActiveLines), 32'(tv[i].e_lines));
            chk($sformatf("f%0d_total", i), 32'(mon.oLineTotal), 32'(tv[i].e_total));
            chk($sformatf("f%0d_sum", i), mon.oChecksum, tv[i].e_sum);
            chk($sformatf("f%0d_probe", i), 32'(mon.oProbeColor), 32'(tv[i].e_probe));
            chk($sformatf("f%0d_ok", i), 32'(mon.oFrameOk), 32'(tv[i].e_ok));
            chk($sformatf("f%0d_locked", i), 32'(mon.oLocked), 32'(tv[i].e_lk));
            chk($sformatf("f%0d_err", i), 32'(mon.oErrCount), 32'(tv[i].e_err));
        end
        chk("done_idle", 32'(mon.oFrameDone), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
